// File: rtl/vga_sync_gen_if.sv
// Configuration bus for vga_sync_gen: a new timing set plus its load strobe,
// and the pending flag returned by the generator.
`timescale 1ns/1ps
interface vga_sync_gen_if #(parameter int W = 12);
    logic         cfg_load;
    logic [W-1:0] cfg_h_active;
    logic [W-1:0] cfg_h_fp;
    logic [W-1:0] cfg_h_sync;
    logic [W-1:0] cfg_h_bp;
    logic [W-1:0] cfg_v_active;
    logic [W-1:0] cfg_v_fp;
    logic [W-1:0] cfg_v_sync;
    logic [W-1:0] cfg_v_bp;
    logic         cfg_h_neg;
    logic         cfg_v_neg;
    logic         cfg_pending;

    // Host side: drives the timing set, watches the pending flag.
    modport master (
        output cfg_load, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_h_neg, cfg_v_neg,
        input  cfg_pending
    );

    // Generator side.
    modport slave (
        input  cfg_load, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_h_neg, cfg_v_neg,
        output cfg_pending
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Programmable video sync generator. Timing changes are staged in a shadow
// set and swapped into the live set only on the last pixel of a frame.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | live timing in use, no shadow set waiting
// PENDING | shadow set captured, applied at the next frame boundary
`timescale 1ns/1ps
module vga_sync_gen #(
    parameter int W        = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 31,
    parameter bit H_NEG    = 1'b1,
    parameter bit V_NEG    = 1'b1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          pix_en,
    vga_sync_gen_if.slave cfg,
    output logic          hsync,
    output logic          vsync,
    output logic          picture,
    output logic [W-1:0]  x,
    output logic [W-1:0]  y,
    output logic          line_start,
    output logic          frame_start
);
    // Region boundaries are summed two bits wider than a field so that a
    // total of exactly 2^W does not overflow.
    localparam int TW = W + 2;

    typedef struct packed {
        logic [W-1:0] h_active;
        logic [W-1:0] h_fp;
        logic [W-1:0] h_sync;
        logic [W-1:0] h_bp;
        logic [W-1:0] v_active;
        logic [W-1:0] v_fp;
        logic [W-1:0] v_sync;
        logic [W-1:0] v_bp;
        logic         h_neg;
        logic         v_neg;
    } timing_t;

    localparam timing_t DEFAULTS = '{
        h_active: W'(H_ACTIVE), h_fp: W'(H_FP), h_sync: W'(H_SYNC), h_bp: W'(H_BP),
        v_active: W'(V_ACTIVE), v_fp: W'(V_FP), v_sync: W'(V_SYNC), v_bp: W'(V_BP),
        h_neg: H_NEG, v_neg: V_NEG
    };

    typedef enum logic {IDLE, PENDING} state_t;

    state_t       state_q, state_d;
    timing_t      live_q, shadow_q, cfg_in;
    logic [W-1:0] hcnt, vcnt;
    logic [TW-1:0] h_sync_start, h_bp_start, h_total;
    logic [TW-1:0] v_sync_start, v_bp_start, v_total;
    logic         h_last, v_last, frame_end, apply;
    logic         h_sync_on, v_sync_on;

    assign cfg_in = {cfg.cfg_h_active, cfg.cfg_h_fp, cfg.cfg_h_sync, cfg.cfg_h_bp,
                     cfg.cfg_v_active, cfg.cfg_v_fp, cfg.cfg_v_sync, cfg.cfg_v_bp,
                     cfg.cfg_h_neg, cfg.cfg_v_neg};

    assign h_sync_start = TW'(live_q.h_active) + TW'(live_q.h_fp);
    assign h_bp_start   = h_sync_start + TW'(live_q.h_sync);
    assign h_total      = h_bp_start + TW'(live_q.h_bp);
    assign v_sync_start = TW'(live_q.v_active) + TW'(live_q.v_fp);
    assign v_bp_start   = v_sync_start + TW'(live_q.v_sync);
    assign v_total      = v_bp_start + TW'(live_q.v_bp);

    assign h_last    = (TW'(hcnt) == h_total - TW'(1));
    assign v_last    = (TW'(vcnt) == v_total - TW'(1));
    assign frame_end = pix_en && h_last && v_last;

    // A zero-width sync region makes the range empty, so sync never asserts.
    assign h_sync_on = (TW'(hcnt) >= h_sync_start) && (TW'(hcnt) < h_bp_start);
    assign v_sync_on = (TW'(vcnt) >= v_sync_start) && (TW'(vcnt) < v_bp_start);

    assign cfg.cfg_pending = (state_q == PENDING);

    // Configuration state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and shadow-to-live apply decision.
    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_load) state_d = PENDING;
            end
            PENDING: begin
                if (frame_end) begin
                    apply   = 1'b1;
                    state_d = cfg.cfg_load ? PENDING : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Live and shadow timing sets; a load on the apply cycle lands in the
    // shadow after the old shadow has moved to live.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            live_q   <= DEFAULTS;
            shadow_q <= DEFAULTS;
        end else begin
            if (apply)        live_q   <= shadow_q;
            if (cfg.cfg_load) shadow_q <= cfg_in;
        end
    end

    // Pixel and line counters. The apply cycle is always the last pixel of
    // the frame, so the normal wrap already returns both counters to 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (h_last || apply) begin
                hcnt <= '0;
                vcnt <= (v_last || apply) ? '0 : vcnt + W'(1);
            end else begin
                hcnt <= hcnt + W'(1);
            end
        end
    end

    // Registered outputs, one enabled cycle behind the counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= H_NEG;
            vsync       <= V_NEG;
            picture     <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync       <= h_sync_on ^ live_q.h_neg;
            vsync       <= v_sync_on ^ live_q.v_neg;
            picture     <= (hcnt < live_q.h_active) && (vcnt < live_q.v_active);
            x           <= hcnt;
            y           <= vcnt;
            line_start  <= (hcnt == '0);
            frame_start <= (hcnt == '0) && (vcnt == '0);
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a pixel-index model predicts every output on every
// clock; scenarios cover defaults, clock enable, mode changes and reset.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    localparam int W    = 12;
    localparam int D_HA = 20, D_HF = 3, D_HS = 4, D_HB = 5;
    localparam int D_VA = 12, D_VF = 2, D_VS = 2, D_VB = 3;
    localparam bit D_HN = 1'b1, D_VN = 1'b1;
    localparam int D_FRAME = (D_HA + D_HF + D_HS + D_HB) * (D_VA + D_VF + D_VS + D_VB);

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hn, vn;
    } tcfg_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         pix_en = 1'b0;
    logic         hsync, vsync, picture, line_start, frame_start;
    logic [W-1:0] x, y;
    logic [29:0]  dut_vec;

    vga_sync_gen_if #(.W(W)) cfg_bus();

    vga_sync_gen #(
        .W(W), .H_ACTIVE(D_HA), .H_FP(D_HF), .H_SYNC(D_HS), .H_BP(D_HB),
        .V_ACTIVE(D_VA), .V_FP(D_VF), .V_SYNC(D_VS), .V_BP(D_VB),
        .H_NEG(D_HN), .V_NEG(D_VN)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pix_en(pix_en), .cfg(cfg_bus.slave),
        .hsync(hsync), .vsync(vsync), .picture(picture), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    assign dut_vec = {cfg_bus.cfg_pending, hsync, vsync, picture, line_start, frame_start, x, y};

    // Model: the frame is a linear run of pixels; m_pos is the pixel the
    // generator will present next, m_out is what it presents now.
    tcfg_t       m_cur, m_shad, no_cfg;
    bit          m_pend;
    int          m_pos;
    logic [28:0] m_out;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic tcfg_t defaults();
        tcfg_t c;
        c.ha = D_HA; c.hf = D_HF; c.hs = D_HS; c.hb = D_HB;
        c.va = D_VA; c.vf = D_VF; c.vs = D_VS; c.vb = D_VB;
        c.hn = D_HN; c.vn = D_VN;
        return c;
    endfunction

    function automatic tcfg_t make_cfg(int ha, int hf, int hs, int hb,
                                       int va, int vf, int vs, int vb, bit hn, bit vn);
        tcfg_t c;
        c.ha = ha; c.hf = hf; c.hs = hs; c.hb = hb;
        c.va = va; c.vf = vf; c.vs = vs; c.vb = vb;
        c.hn = hn; c.vn = vn;
        return c;
    endfunction

    function automatic tcfg_t rand_cfg();
        tcfg_t c;
        c.ha = $urandom_range(0, 10); c.hf = $urandom_range(0, 3);
        c.hs = $urandom_range(0, 3);  c.hb = $urandom_range(0, 3);
        c.va = $urandom_range(0, 6);  c.vf = $urandom_range(0, 2);
        c.vs = $urandom_range(0, 2);  c.vb = $urandom_range(0, 2);
        if (c.ha + c.hf + c.hs + c.hb == 0) c.hb = 1;
        if (c.va + c.vf + c.vs + c.vb == 0) c.vb = 1;
        c.hn = 1'($urandom_range(0, 1));
        c.vn = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic int frame_len(tcfg_t c);
        return (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
    endfunction

    function automatic logic [28:0] pixel_of(tcfg_t c, int p);
        int  ht, px, py;
        logic hs_on, vs_on, pic;
        ht    = c.ha + c.hf + c.hs + c.hb;
        px    = p % ht;
        py    = p / ht;
        hs_on = (px >= c.ha + c.hf) && (px < c.ha + c.hf + c.hs);
        vs_on = (py >= c.va + c.vf) && (py < c.va + c.vf + c.vs);
        pic   = (px < c.ha) && (py < c.va);
        return {hs_on ^ c.hn, vs_on ^ c.vn, pic, px == 0, p == 0, W'(px), W'(py)};
    endfunction

    task automatic model_reset();
        m_cur  = defaults();
        m_shad = defaults();
        m_pend = 1'b0;
        m_pos  = 0;
        m_out  = {D_HN, D_VN, 3'b000, {W{1'b0}}, {W{1'b0}}};
    endtask

    task automatic drive_cfg(input tcfg_t c);
        cfg_bus.cfg_h_active = W'(c.ha); cfg_bus.cfg_h_fp = W'(c.hf);
        cfg_bus.cfg_h_sync   = W'(c.hs); cfg_bus.cfg_h_bp = W'(c.hb);
        cfg_bus.cfg_v_active = W'(c.va); cfg_bus.cfg_v_fp = W'(c.vf);
        cfg_bus.cfg_v_sync   = W'(c.vs); cfg_bus.cfg_v_bp = W'(c.vb);
        cfg_bus.cfg_h_neg    = c.hn;     cfg_bus.cfg_v_neg = c.vn;
    endtask

    // One clock: drive inputs, advance the model as the DUT should, and
    // return 1 ns after the edge so outputs can be sampled.
    task automatic tick(input bit en, input bit ld, input tcfg_t c);
        pix_en = en;
        cfg_bus.cfg_load = ld;
        if (ld) drive_cfg(c);
        @(posedge clock);
        if (en && reset_n) begin
            m_out = pixel_of(m_cur, m_pos);
            if (m_pos == frame_len(m_cur) - 1) begin
                m_pos = 0;
                if (m_pend) begin
                    m_cur  = m_shad;
                    m_pend = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
        if (ld && reset_n) begin
            m_shad = c;
            m_pend = 1'b1;
        end
        #1;
        cfg_bus.cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, no_cfg);
        n_checks++;
        if (dut_vec !== {m_pend, m_out}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, {m_pend, m_out});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_default_frames();
        int fs_cnt = 0, pic_cnt = 0, hs_cnt = 0, vs_lines = 0;
        for (int i = 0; i < 2 * D_FRAME; i++) begin
            tick(1'b1, 1'b0, no_cfg);
            fs_cnt  += int'(frame_start);
            pic_cnt += int'(picture);
            hs_cnt  += int'(!hsync);
            vs_lines += int'(!vsync && line_start);
            n_checks++;
            if (dut_vec !== {m_pend, m_out}) begin
                n_fail++;
                $display("FAIL default_frames pos %0d: got %h expected %h", m_pos, dut_vec, {m_pend, m_out});
            end
        end
        n_checks++;
        if (fs_cnt !== 2 || pic_cnt !== 2 * D_HA * D_VA) begin
            n_fail++;
            $display("FAIL default_counts: frame_start %0d (need 2) picture %0d (need %0d)", fs_cnt, pic_cnt, 2 * D_HA * D_VA);
        end
        n_checks++;
        if (hs_cnt !== 2 * D_HS * (D_VA + D_VF + D_VS + D_VB) || vs_lines !== 2 * D_VS) begin
            n_fail++;
            $display("FAIL default_sync_widths: hsync cycles %0d vsync lines %0d", hs_cnt, vs_lines);
        end
    endtask

    task automatic test_pix_en_stretch();
        for (int i = 0; i < 3 * D_FRAME; i++) begin
            tick(i % 3 == 0, 1'b0, no_cfg);
            n_checks++;
            if (dut_vec !== {m_pend, m_out}) begin
                n_fail++;
                $display("FAIL pix_en_stretch cycle %0d: got %h expected %h", i, dut_vec, {m_pend, m_out});
            end
        end
    endtask

    task automatic test_cfg_mid_frame();
        int guard = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0;
        tcfg_t c = make_cfg(8, 2, 3, 1, 4, 1, 1, 1, 1'b0, 1'b0);
        for (int i = 0; i < int'($urandom_range(10, 200)); i++) tick(1'b1, 1'b0, no_cfg);
        tick(1'b1, 1'b1, c);
        while (m_pend && guard < 3 * D_FRAME) begin
            tick(1'b1, 1'b0, no_cfg);
            guard++;
            n_checks++;
            if (dut_vec !== {m_pend, m_out}) begin
                n_fail++;
                $display("FAIL cfg_mid_frame_wait: got %h expected %h", dut_vec, {m_pend, m_out});
            end
        end
        n_checks++;
        if (m_pend || cfg_bus.cfg_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_mid_frame_apply: cfg_pending %b after %0d cycles, need 0", cfg_bus.cfg_pending, guard);
        end
        for (int i = 0; i < 3 * 98; i++) begin
            tick(1'b1, 1'b0, no_cfg);
            fs_cnt += int'(frame_start);
            hs_cnt += int'(hsync);
            vs_cnt += int'(vsync);
            n_checks++;
            if (dut_vec !== {m_pend, m_out}) begin
                n_fail++;
                $display("FAIL cfg_mid_frame_new: got %h expected %h", dut_vec, {m_pend, m_out});
            end
        end
        n_checks++;
        if (fs_cnt !== 3 || hs_cnt !== 63 || vs_cnt !== 42) begin
            n_fail++;
            $display("FAIL cfg_mid_frame_counts: frame_start %0d/3 hsync %0d/63 vsync %0d/42", fs_cnt, hs_cnt, vs_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        tcfg_t a = rand_cfg(), b = rand_cfg(), c = rand_cfg();
        while (m_pos != 1 && guard < 2 * D_FRAME) begin tick(1'b1, 1'b0, no_cfg); guard++; end
        tick(1'b1, 1'b1, a);
        tick(1'b1, 1'b0, no_cfg);
        tick(1'b1, 1'b1, b);
        guard = 0;
        while (m_pos != frame_len(m_cur) - 1 && guard < 2 * D_FRAME) begin
            tick(1'b1, 1'b0, no_cfg);
            guard++;
            n_checks++;
            if (dut_vec !== {m_pend, m_out}) begin
                n_fail++;
                $display("FAIL back_to_back_wait: got %h expected %h", dut_vec, {m_pend, m_out});
            end
        end
        tick(1'b1, 1'b1, c);
        n_checks++;
        if (dut_vec !== {m_pend, m_out} || cfg_bus.cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_boundary: got %h expected %h", dut_vec, {m_pend, m_out});
        end
        for (int i = 0; i < frame_len(b) + 2 * frame_len(c); i++) begin
            tick(1'b1, 1'b0, no_cfg);
            n_checks++;
            if (dut_vec !== {m_pend, m_out}) begin
                n_fail++;
                $display("FAIL back_to_back_run: got %h expected %h", dut_vec, {m_pend, m_out});
            end
        end
    endtask

    task automatic test_zero_regions();
        int guard = 0, bad_hs = 0, max_x = 0;
        tcfg_t c = make_cfg(4, 0, 0, 0, 3, 1, 1, 1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, c);
        while (m_pend && guard < 4 * D_FRAME) begin
            tick(1'b1, 1'b0, no_cfg);
            guard++;
        end
        for (int i = 0; i < 3 * 24; i++) begin
            tick($urandom_range(0, 3) != 0, 1'b0, no_cfg);
            bad_hs += int'(hsync !== 1'b0);
            if (int'(x) > max_x) max_x = int'(x);
            n_checks++;
            if (dut_vec !== {m_pend, m_out}) begin
                n_fail++;
                $display("FAIL zero_regions: got %h expected %h", dut_vec, {m_pend, m_out});
            end
        end
        n_checks++;
        if (bad_hs !== 0 || max_x !== 3) begin
            n_fail++;
            $display("FAIL zero_regions_shape: hsync active %0d cycles (need 0), max x %0d (need 3)", bad_hs, max_x);
        end
    endtask

    task automatic test_random_modes();
        for (int k = 0; k < 6; k++) begin
            int guard = 0;
            tcfg_t c = rand_cfg();
            for (int i = 0; i < int'($urandom_range(0, 30)); i++) tick(1'b1, 1'b0, no_cfg);
            tick($urandom_range(0, 1) == 1, 1'b1, c);
            while ((m_pend || guard < 2 * frame_len(c)) && guard < 4000) begin
                tick($urandom_range(0, 2) != 0, 1'b0, no_cfg);
                guard++;
                n_checks++;
                if (dut_vec !== {m_pend, m_out}) begin
                    n_fail++;
                    $display("FAIL random_mode %0d: got %h expected %h", k, dut_vec, {m_pend, m_out});
                end
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        tick(1'b1, 1'b1, rand_cfg());
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, no_cfg);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec !== {m_pend, m_out}) begin
            n_fail++;
            $display("FAIL reset_mid_pending: got %h expected %h", dut_vec, {m_pend, m_out});
        end
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < D_FRAME + 5; i++) begin
            tick(1'b1, 1'b0, no_cfg);
            n_checks++;
            if (dut_vec !== {m_pend, m_out}) begin
                n_fail++;
                $display("FAIL reset_resume pos %0d: got %h expected %h", m_pos, dut_vec, {m_pend, m_out});
            end
        end
    endtask

    initial begin
        no_cfg = defaults();
        cfg_bus.cfg_load = 1'b0;
        drive_cfg(defaults());
        test_reset();
        test_default_frames();
        test_pix_en_stretch();
        test_cfg_mid_frame();
        test_back_to_back();
        test_zero_regions();
        test_random_modes();
        test_reset_mid_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
